sqrt_combine: RTL and testbench
===============================

// Module: sqrt_combine
// PURPOSE
//  Downstream of the polynomial splitter in the Patterson decode path. Consumes T0(x), T1(x)
//  (T(x) = T0(x)^2 + x*T1(x)^2) and forms R(x) = sqrt(T(x)) mod g(x) = T0(x) + S(x)*T1(x) mod g(x),
//  with S(x) = sqrt(x) mod g(x) precomputed. Coefficient-serial Horner evaluation, two GF(2^16) mults/cycle.
// PARAMETERS
//  COEF_W      16       bits per GF(2^m) coefficient
//  NCOEF       9        coefficients per polynomial = deg g(x); bus width m = COEF_W*NCOEF = 144
//  FIELD_POLY  16'h002B low COEF_W bits of field polynomial (x^16+x^5+x^3+x+1)
// PORTS
//  clk                  in   1    clock, rising edge
//  rst                  in   1    asynchronous reset, active-high
//  start                in   1    begin combine; sampled only in IDLE
//  first_fragment_in    in   m    T0(x); coeff k at bits [COEF_W*k +: COEF_W] of [0:m-1] bus, k = power of x
//  second_fragment_in   in   m    T1(x); same packing
//  sqrtx_in             in   m    S(x) = sqrt(x) mod g(x); same packing
//  goppa_in             in   m    g(x) coeffs 0..NCOEF-1; g monic, x^NCOEF term implicit
//  result_out           out  m    R(x); same packing
//  busy                 out  1    high in every state except IDLE
//  combine_done         out  1    one-cycle pulse, high in DONE
// BEHAVIOUR
//  Reset (async, any time incl. mid-operation): state=IDLE, acc/result_out/operand regs=0, busy=0, combine_done=0.
//  States: IDLE -> LOAD -> {PREP -> MAC x NCOEF} x NCOEF -> ADD -> DONE -> IDLE.
//  - IDLE: start=1 captures all four input buses into internal regs; inputs free to change afterwards.
//  - LOAD: acc=0, i=NCOEF-1.
//  - PREP: top<=acc[NCOEF-1], t<=T1[i], j<=NCOEF-1.
//  - MAC (j descending, one coeff/cycle): acc[j] <= (j==0 ? 0 : acc[j-1]) ^ gfmul(top,g[j]) ^ gfmul(t,S[j]);
//    descending j guarantees acc[j-1] is still the pre-step value. At j==0: i==0 -> ADD, else i--, -> PREP.
//  - ADD: result_out <= acc ^ T0 (coefficient-wise XOR).  DONE: combine_done=1 for exactly one cycle.
//  Latency: DONE entered NCOEF*(NCOEF+1)+2 rising edges after the edge sampling start (92 for NCOEF=9).
//  result_out changes only in ADD; holds last result through IDLE and the next operation until its ADD.
//  start while busy: ignored, no restart, no queueing. start held high: new op starts on first IDLE cycle.
//  GF arithmetic: add = XOR; gfmul = polynomial product of two COEF_W-bit values reduced by FIELD_POLY,
//  purely combinational, result COEF_W bits. Counters i, j: $clog2(NCOEF) bits, never wrap past 0.
//  combine_done and busy decoded from state register (no extra register stage).
// STRUCTURE
//  Shared package: COEF_W, NCOEF, FIELD_POLY defaults, state encoding (IDLE..DONE), coefficient-slice macro.
//  Sub-module gf16_mul (a, b -> a*b mod FIELD_POLY), instantiated twice: (top,g[j]) and (t,S[j]).
//  Coefficient select of g[j]/S[j]/acc[j-1] by j via mux; acc stored as NCOEF x COEF_W register array.
// TESTING
//  T1=0, T0=random -> result_out==T0, combine_done pulse 92 edges after start edge.
//  T0=0, T1=1 (coeff0=0x0001), S random -> result_out==S.
//  S=1, T0=0x..., T1 random -> result_out==T0^T1.
//  Field reduction: T0=0, S coeff0=0x0002, T1 coeff0=0x8000, else 0 -> result coeff0==0x002B.
//  Ring reduction: S=x (coeff1=1), T1 coeff NCOEF-1=1, T0=0 -> result_out==goppa_in (x^NCOEF mod g).
//  rst pulse at MAC cycle 40 -> all outputs 0, IDLE next; start pulse while busy -> no effect on result/timing.

Source files
------------

// File: rtl/sqrt_combine_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sqrt_combine_pkg
// Description : Shared definitions for the sqrt_combine block: default field
//               and polynomial sizes, FSM state encoding and a helper macro
//               for selecting one coefficient out of a packed polynomial bus.
// Revision    : 1.0 - initial release
// ============================================================================

// Select coefficient k (power of x) of width w from a packed polynomial bus.
`ifndef SC_COEF
`define SC_COEF(bus, k, w) bus[(w)*(k) +: (w)]
`endif

package sqrt_combine_pkg;

    // Default GF(2^16) coefficient width and polynomial length (deg g(x)).
    localparam int          COEF_W_DEF     = 16;
    localparam int          NCOEF_DEF      = 9;
    // Low 16 bits of x^16 + x^5 + x^3 + x + 1.
    localparam logic [15:0] FIELD_POLY_DEF = 16'h002B;

    // Combine sequencer states.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_PREP = 3'd2,
        ST_MAC  = 3'd3,
        ST_ADD  = 3'd4,
        ST_DONE = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/sqrt_combine_gf16_mul.sv
`default_nettype none
// ============================================================================
// Module      : gf16_mul
// Description : Combinational GF(2^COEF_W) multiplier. Forms the carry-less
//               product of i_a and i_b and reduces it by the field polynomial
//               (x^COEF_W term implicit) using an interleaved shift-and-add.
// Ports       : i_a, i_b - field elements (COEF_W bits)
//               o_p      - i_a * i_b mod FIELD_POLY (COEF_W bits)
// Revision    : 1.0 - initial release
// ============================================================================
module gf16_mul #(
    parameter int                COEF_W     = 16,
    parameter logic [COEF_W-1:0] FIELD_POLY = 16'h002B
) (
    input  logic [COEF_W-1:0] i_a,
    input  logic [COEF_W-1:0] i_b,
    output logic [COEF_W-1:0] o_p
);

    logic [COEF_W-1:0] w_acc;
    logic [COEF_W-1:0] w_sh;

    // w_sh walks through i_a * x^k mod f(x); reducing on every shift keeps the
    // partial product inside COEF_W bits, so no final reduction pass is needed.
    always_comb begin
        w_acc = '0;
        w_sh  = i_a;
        for (int k = 0; k < COEF_W; k++) begin
            if (i_b[k]) begin
                w_acc = w_acc ^ w_sh;
            end
            w_sh = {w_sh[COEF_W-2:0], 1'b0} ^ (w_sh[COEF_W-1] ? FIELD_POLY : '0);
        end
    end

    assign o_p = w_acc;

endmodule
`default_nettype wire

// File: rtl/sqrt_combine.sv
`default_nettype none
// ============================================================================
// Module      : sqrt_combine
// Description : Forms R(x) = T0(x) + S(x)*T1(x) mod g(x), i.e. sqrt(T(x)) mod
//               g(x) for the Patterson decoder. T1(x)*S(x) mod g(x) is built
//               by coefficient-serial Horner evaluation over the coefficients
//               of T1, highest power first: acc <- acc*x + T1[i]*S  (mod g).
//               Each MAC cycle updates one accumulator coefficient using two
//               GF(2^16) multipliers.
// Ports       : clk, rst            - clock, asynchronous active-high reset
//               start               - begin an operation (sampled in IDLE)
//               first_fragment_in   - T0(x), coeff k at [COEF_W*k +: COEF_W]
//               second_fragment_in  - T1(x), same packing
//               sqrtx_in            - S(x) = sqrt(x) mod g(x), same packing
//               goppa_in            - g(x) coeffs 0..NCOEF-1, monic implicit
//               result_out          - R(x), held until the next ADD
//               busy                - high in every state except IDLE
//               combine_done        - one-cycle pulse in DONE
// Revision    : 1.0 - initial release
// ============================================================================
module sqrt_combine
    import sqrt_combine_pkg::*;
#(
    parameter int                COEF_W     = COEF_W_DEF,
    parameter int                NCOEF      = NCOEF_DEF,
    parameter logic [COEF_W-1:0] FIELD_POLY = COEF_W'(FIELD_POLY_DEF)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [COEF_W*NCOEF-1:0] first_fragment_in,
    input  logic [COEF_W*NCOEF-1:0] second_fragment_in,
    input  logic [COEF_W*NCOEF-1:0] sqrtx_in,
    input  logic [COEF_W*NCOEF-1:0] goppa_in,
    output logic [COEF_W*NCOEF-1:0] result_out,
    output logic                    busy,
    output logic                    combine_done
);

    localparam int M_W   = COEF_W * NCOEF;
    localparam int IDX_W = (NCOEF > 1) ? $clog2(NCOEF) : 1;

    localparam logic [IDX_W-1:0] c_LAST = IDX_W'(NCOEF - 1);
    localparam logic [IDX_W-1:0] c_ONE  = IDX_W'(1);

    // ------------------------------------------------------------------
    // State and operand registers
    // ------------------------------------------------------------------
    state_t            r_state;
    logic [M_W-1:0]    r_t0;
    logic [M_W-1:0]    r_t1;
    logic [M_W-1:0]    r_s;
    logic [M_W-1:0]    r_g;
    logic [M_W-1:0]    r_result;
    logic [COEF_W-1:0] r_acc [NCOEF];
    logic [COEF_W-1:0] r_top;      // acc[NCOEF-1] frozen for the whole *x pass
    logic [COEF_W-1:0] r_t;        // T1[i] for the current Horner step
    logic [IDX_W-1:0]  r_i;        // Horner step (T1 coefficient index)
    logic [IDX_W-1:0]  r_j;        // accumulator coefficient being updated

    // ------------------------------------------------------------------
    // Datapath: per-cycle coefficient selects and the two multipliers
    // ------------------------------------------------------------------
    logic [IDX_W-1:0]  w_jm1;
    logic [COEF_W-1:0] w_acc_prev;
    logic [COEF_W-1:0] w_g_j;
    logic [COEF_W-1:0] w_s_j;
    logic [COEF_W-1:0] w_prod_g;
    logic [COEF_W-1:0] w_prod_s;
    logic [COEF_W-1:0] w_acc_next;

    assign w_jm1 = r_j - c_ONE;
    assign w_g_j = `SC_COEF(r_g, r_j, COEF_W);
    assign w_s_j = `SC_COEF(r_s, r_j, COEF_W);

    // Multiplying acc by x shifts coefficients up one place; j==0 takes a zero.
    // Descending j means acc[j-1] has not yet been overwritten this pass.
    always_comb begin
        w_acc_prev = '0;
        if (r_j != '0) begin
            w_acc_prev = r_acc[w_jm1];
        end
    end

    // The x^NCOEF overflow term folds back as top*g(x) (characteristic 2,
    // so subtraction of g is the same XOR as addition).
    gf16_mul #(
        .COEF_W     (COEF_W),
        .FIELD_POLY (FIELD_POLY)
    ) u_mul_g (
        .i_a (r_top),
        .i_b (w_g_j),
        .o_p (w_prod_g)
    );

    gf16_mul #(
        .COEF_W     (COEF_W),
        .FIELD_POLY (FIELD_POLY)
    ) u_mul_s (
        .i_a (r_t),
        .i_b (w_s_j),
        .o_p (w_prod_s)
    );

    assign w_acc_next = w_acc_prev ^ w_prod_g ^ w_prod_s;

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_t0     <= '0;
            r_t1     <= '0;
            r_s      <= '0;
            r_g      <= '0;
            r_result <= '0;
            r_top    <= '0;
            r_t      <= '0;
            r_i      <= '0;
            r_j      <= '0;
            for (int k = 0; k < NCOEF; k++) begin
                r_acc[k] <= '0;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_t0    <= first_fragment_in;
                        r_t1    <= second_fragment_in;
                        r_s     <= sqrtx_in;
                        r_g     <= goppa_in;
                        r_state <= ST_LOAD;
                    end
                end

                ST_LOAD: begin
                    for (int k = 0; k < NCOEF; k++) begin
                        r_acc[k] <= '0;
                    end
                    r_i     <= c_LAST;
                    r_state <= ST_PREP;
                end

                ST_PREP: begin
                    r_top   <= r_acc[NCOEF-1];
                    r_t     <= `SC_COEF(r_t1, r_i, COEF_W);
                    r_j     <= c_LAST;
                    r_state <= ST_MAC;
                end

                ST_MAC: begin
                    r_acc[r_j] <= w_acc_next;
                    if (r_j == '0) begin
                        if (r_i == '0) begin
                            r_state <= ST_ADD;
                        end else begin
                            r_i     <= r_i - c_ONE;
                            r_state <= ST_PREP;
                        end
                    end else begin
                        r_j <= w_jm1;
                    end
                end

                ST_ADD: begin
                    for (int k = 0; k < NCOEF; k++) begin
                        r_result[COEF_W*k +: COEF_W] <= r_acc[k] ^ r_t0[COEF_W*k +: COEF_W];
                    end
                    r_state <= ST_DONE;
                end

                ST_DONE: begin
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign result_out   = r_result;
    assign busy         = (r_state != ST_IDLE);
    assign combine_done = (r_state == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_sqrt_combine.sv
`default_nettype none
// ============================================================================
// Module      : tb_sqrt_combine
// Description : Self-checking bench for sqrt_combine. Directed vectors with
//               hand-derived expectations, random vectors against a reference
//               model (full polynomial product followed by long division by
//               g(x)), plus latency, reset-mid-operation and start-while-busy
//               sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sqrt_combine;

    localparam int COEF_W = 16;
    localparam int NCOEF  = 9;
    localparam int M_W    = COEF_W * NCOEF;
    localparam int LAT    = NCOEF * (NCOEF + 1) + 2;

    typedef logic [M_W-1:0] bus_t;

    typedef struct packed {
        bus_t t0;
        bus_t t1;
        bus_t s;
        bus_t g;
        bus_t exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    bus_t first_fragment_in  = '0;
    bus_t second_fragment_in = '0;
    bus_t sqrtx_in           = '0;
    bus_t goppa_in           = '0;
    bus_t result_out;
    logic busy;
    logic combine_done;

    int n_checks = 0;
    int n_errors = 0;

    sqrt_combine dut (
        .clk                (clk),
        .rst                (rst),
        .start              (start),
        .first_fragment_in  (first_fragment_in),
        .second_fragment_in (second_fragment_in),
        .sqrtx_in           (sqrtx_in),
        .goppa_in           (goppa_in),
        .result_out         (result_out),
        .busy               (busy),
        .combine_done       (combine_done)
    );

    always #5 clk = ~clk;

    // ---------------------------------------------------------------
    // Reference model
    // ---------------------------------------------------------------
    function automatic logic [15:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
        logic [31:0] p;
        p = '0;
        for (int i = 0; i < 16; i++) begin
            if (b[i]) p = p ^ (32'(a) << i);
        end
        for (int k = 30; k >= 16; k--) begin
            if (p[k]) p = p ^ (32'h0001_002B << (k - 16));
        end
        return p[15:0];
    endfunction

    // T0 + (T1 * S mod g): schoolbook product, then reduce using x^9 = g_low.
    function automatic bus_t ref_combine(input bus_t t0, input bus_t t1, input bus_t s, input bus_t g);
        logic [15:0] prod [2*NCOEF-1];
        logic [15:0] c;
        bus_t r;
        for (int k = 0; k < 2*NCOEF-1; k++) prod[k] = '0;
        for (int a = 0; a < NCOEF; a++)
            for (int b = 0; b < NCOEF; b++)
                prod[a+b] = prod[a+b] ^ ref_mul(t1[16*a +: 16], s[16*b +: 16]);
        for (int d = 2*NCOEF-2; d >= NCOEF; d--) begin
            c = prod[d];
            prod[d] = '0;
            for (int k = 0; k < NCOEF; k++)
                prod[d-NCOEF+k] = prod[d-NCOEF+k] ^ ref_mul(c, g[16*k +: 16]);
        end
        for (int k = 0; k < NCOEF; k++) r[16*k +: 16] = prod[k] ^ t0[16*k +: 16];
        return r;
    endfunction

    function automatic bus_t rand_bus();
        bus_t b;
        for (int k = 0; k < NCOEF; k++) b[16*k +: 16] = 16'($urandom);
        return b;
    endfunction

    // ---------------------------------------------------------------
    // Check helpers
    // ---------------------------------------------------------------
    task automatic chk_bus(input string name, input bus_t act, input bus_t exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Runs one operation. Inputs are scrambled right after the start edge to
    // show they were captured. If glitch > 0, a start pulse with unrelated
    // data is applied glitch edges into the operation.
    task automatic run_op(input string name, input bus_t t0, input bus_t t1, input bus_t s,
                          input bus_t g, input int glitch, output bus_t res);
        int lat;
        @(negedge clk);
        first_fragment_in  = t0;
        second_fragment_in = t1;
        sqrtx_in           = s;
        goppa_in           = g;
        start              = 1'b1;
        @(posedge clk);
        #1;
        start              = 1'b0;
        first_fragment_in  = rand_bus();
        second_fragment_in = rand_bus();
        sqrtx_in           = rand_bus();
        goppa_in           = rand_bus();
        chk_int({name, " busy after start"}, int'(busy), 1);
        lat = -1;
        for (int n = 1; n <= 3*LAT; n++) begin
            @(posedge clk);
            #1;
            if (glitch > 0 && n == glitch) start = 1'b1;
            if (glitch > 0 && n == glitch + 1) start = 1'b0;
            if (combine_done) begin
                lat = n;
                break;
            end
        end
        chk_int({name, " latency"}, lat, LAT);
        res = result_out;
        @(posedge clk);
        #1;
        chk_int({name, " done one cycle"}, int'(combine_done), 0);
        chk_int({name, " idle after done"}, int'(busy), 0);
    endtask

    // ---------------------------------------------------------------
    // Stimulus
    // ---------------------------------------------------------------
    vec_t vecs [5];
    bus_t res;
    bus_t g0, x0, x1, x2, exp_b;

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk_bus("reset result_out", result_out, '0);
        chk_int("reset busy", int'(busy), 0);
        chk_int("reset combine_done", int'(combine_done), 0);
        @(negedge clk);
        rst = 1'b0;

        g0 = rand_bus();

        // 0: T1 = 0 -> R = T0
        x0 = rand_bus();
        vecs[0] = '{t0: x0, t1: '0, s: rand_bus(), g: g0, exp: x0};
        // 1: T0 = 0, T1 = 1 -> R = S
        x1 = rand_bus();
        vecs[1] = '{t0: '0, t1: bus_t'(16'h0001), s: x1, g: g0, exp: x1};
        // 2: S = 1 -> R = T0 ^ T1
        x0 = rand_bus();
        x2 = rand_bus();
        vecs[2] = '{t0: x0, t1: x2, s: bus_t'(16'h0001), g: g0, exp: x0 ^ x2};
        // 3: field reduction, x^15 * x = x^16 = 0x002B
        vecs[3] = '{t0: '0, t1: bus_t'(16'h8000), s: bus_t'(16'h0002), g: g0,
                    exp: bus_t'(16'h002B)};
        // 4: ring reduction, x^8 * x = x^9 mod g = g_low
        x2 = '0;
        x2[16*(NCOEF-1) +: 16] = 16'h0001;
        vecs[4] = '{t0: '0, t1: x2, s: bus_t'(32'h0001_0000), g: g0, exp: g0};

        for (int v = 0; v < 5; v++) begin
            run_op($sformatf("vec%0d", v), vecs[v].t0, vecs[v].t1, vecs[v].s, vecs[v].g, 0, res);
            chk_bus($sformatf("vec%0d result", v), res, vecs[v].exp);
        end

        // Random vectors against the reference model
        for (int r = 0; r < 6; r++) begin
            x0 = rand_bus();
            x1 = rand_bus();
            x2 = rand_bus();
            g0 = rand_bus();
            exp_b = ref_combine(x0, x1, x2, g0);
            run_op($sformatf("rand%0d", r), x0, x1, x2, g0, 0, res);
            chk_bus($sformatf("rand%0d result", r), res, exp_b);
        end

        // Start pulse while busy: no restart, result and timing unchanged
        x0 = rand_bus();
        x1 = rand_bus();
        x2 = rand_bus();
        g0 = rand_bus();
        exp_b = ref_combine(x0, x1, x2, g0);
        run_op("glitch", x0, x1, x2, g0, 30, res);
        chk_bus("glitch result", res, exp_b);

        // Asynchronous reset in the middle of the MAC phase
        @(negedge clk);
        first_fragment_in  = rand_bus();
        second_fragment_in = rand_bus();
        sqrtx_in           = rand_bus();
        goppa_in           = g0;
        start              = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (45) @(posedge clk);
        #1;
        chk_int("pre-reset busy", int'(busy), 1);
        rst = 1'b1;
        #1;
        chk_bus("midreset result_out", result_out, '0);
        chk_int("midreset busy", int'(busy), 0);
        chk_int("midreset combine_done", int'(combine_done), 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk_int("post-reset idle", int'(busy), 0);
        chk_bus("post-reset result_out", result_out, '0);

        // Operation after reset recovers normally
        x0 = rand_bus();
        x1 = rand_bus();
        x2 = rand_bus();
        g0 = rand_bus();
        exp_b = ref_combine(x0, x1, x2, g0);
        run_op("after_reset", x0, x1, x2, g0, 0, res);
        chk_bus("after_reset result", res, exp_b);

        // Result holds through IDLE
        repeat (5) @(posedge clk);
        #1;
        chk_bus("result hold", result_out, exp_b);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
